// File: rtl/dlx_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_hazard_ctrl
//  Purpose  : Hazard and forwarding controller for the 5-stage DLX pipeline.
//             Tracks in-flight destination registers past ID, and each cycle
//             decides whether to stall, insert a bubble, flush, or forward.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             id_*                - decoded fields of the instruction in ID
//             branch_taken        - taken branch resolved in MEM
//             stall, bubble_id_ex - hold PC/IF-ID, zero ID/EX (combinational)
//             flush               - squash IF/ID, ID/EX, EX/MEM (combinational)
//             fwd_a, fwd_b        - EX operand source, 0 = regfile, k = entry k
//             stall_cnt           - saturating count of stall cycles
//  Revision : 1.0 - initial release
// ============================================================================
module dlx_hazard_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              branch_taken,
   output logic              stall,
   output logic              bubble_id_ex,
   output logic              flush,
   output logic [2:0]        fwd_a,
   output logic [2:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   // The WB entry (e[DEPTH]) can never cause a hazard or a forward because the
   // register file is write-through, so only entries 1..DEPTH-1 are stored.
   // mem_read only matters for the load-use check on entry 1.
   localparam int LIVE = DEPTH - 1;

   logic [LIVE:1]     e_valid_q, e_valid_d;
   logic [LIVE:1]     e_rw_q,    e_rw_d;
   logic [ADDR_W-1:0] e_rd_q [1:LIVE];
   logic [ADDR_W-1:0] e_rd_d [1:LIVE];
   logic              e1_mr_q,   e1_mr_d;

   logic [2:0]        fwd_a_q, fwd_a_d;
   logic [2:0]        fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [LIVE:1]     match_a, match_b;
   logic              hazard;

   // ---------------------------------------------------------------- matching
   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 1; k <= LIVE; k++) begin
         if (e_valid_q[k] && e_rw_q[k] && (e_rd_q[k] != '0)) begin
            match_a[k] = (e_rd_q[k] == id_rs);
            match_b[k] = id_uses_rt && (e_rd_q[k] == id_rt);
         end
      end
   end

   // ------------------------------------------------------------------ hazard
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN != 0) begin
         // Only a load in EX cannot be bypassed in time.
         hazard = id_valid && e1_mr_q && (match_a[1] || match_b[1]);
      end else begin
         hazard = id_valid && ((|match_a) || (|match_b));
      end
   end

   assign flush        = branch_taken;
   assign stall        = hazard && !branch_taken;
   assign bubble_id_ex = stall;

   // --------------------------------------------------------- forward select
   // Scan oldest to youngest so the youngest producer overwrites.
   always_comb begin
      fwd_a_d = '0;
      fwd_b_d = '0;
      if ((FWD_EN != 0) && !stall && !flush) begin
         for (int k = LIVE; k >= 1; k--) begin
            if (match_a[k]) fwd_a_d = 3'(k + 1);
            if (match_b[k]) fwd_b_d = 3'(k + 1);
         end
      end
   end

   // ------------------------------------------------------ scoreboard shift
   always_comb begin
      e_valid_d    = '0;
      e_rw_d       = '0;
      e_rd_d       = e_rd_q;
      e_valid_d[1] = id_valid && !stall && !flush;
      e_rw_d[1]    = id_reg_write;
      e_rd_d[1]    = id_rd;
      e1_mr_d      = id_mem_read;
      for (int k = 2; k <= LIVE; k++) begin
         // On flush the instruction leaving EX is squashed along with ID.
         e_valid_d[k] = e_valid_q[k-1] && !(flush && (k == 2));
         e_rw_d[k]    = e_rw_q[k-1];
         e_rd_d[k]    = e_rd_q[k-1];
      end
   end

   // ----------------------------------------------------------- stall counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // --------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid_q   <= '0;
         e_rw_q      <= '0;
         e1_mr_q     <= 1'b0;
         for (int k = 1; k <= LIVE; k++) begin
            e_rd_q[k] <= '0;
         end
         fwd_a_q     <= '0;
         fwd_b_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         e_valid_q   <= e_valid_d;
         e_rw_q      <= e_rw_d;
         e1_mr_q     <= e1_mr_d;
         e_rd_q      <= e_rd_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire
